// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: I-side, D-side and shared memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [3:0]  i_rmask;
  logic        i_flush;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_rmask;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  modport slave(
    input  i_req, i_addr, i_rmask, i_flush, d_req, d_addr, d_rmask, d_wmask, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_rmask, mem_wmask, mem_wdata
  );
  modport master(
    output i_req, i_addr, i_rmask, i_flush, d_req, d_addr, d_rmask, d_wmask, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_rmask, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I-fetch and D-side with bounded D priority and fetch flush draining
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DRAIN_I, LOCAL_D} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    rmask_q, rmask_d, wmask_q, wmask_d;
  logic          i_elig, d_win, i_win, d_mem, drive, i_done, d_done;
  always_comb begin
    i_elig   = bus.i_req && !bus.i_flush;
    d_win    = state_q == IDLE && bus.d_req && (!i_elig || streak_q < SMAX);
    i_win    = state_q == IDLE && !d_win && i_elig;
    d_mem    = |bus.d_rmask || |bus.d_wmask;
    state_d  = state_q == IDLE    ? (d_win ? (d_mem ? BUSY_D : LOCAL_D) : i_win ? BUSY_I : IDLE)
             : state_q == BUSY_I  ? (bus.mem_resp ? IDLE : bus.i_flush ? DRAIN_I : BUSY_I)
             : state_q == LOCAL_D ? IDLE
             : bus.mem_resp       ? IDLE : state_q;
    streak_d = d_win ? (i_elig ? (streak_q == SMAX ? SMAX : streak_q + SW'(1)) : '0)
             : i_win ? '0 : streak_q;
    addr_d   = d_win ? bus.d_addr : i_win ? bus.i_addr : addr_q;
    wdata_d  = d_win ? bus.d_wdata : i_win ? '0 : wdata_q;
    // masks live only in the first BUSY cycle, giving a one-cycle strobe
    rmask_d  = d_win ? bus.d_rmask : i_win ? bus.i_rmask : '0;
    wmask_d  = d_win ? bus.d_wmask : '0;
    drive    = !rst && (state_q == BUSY_I || state_q == BUSY_D || state_q == DRAIN_I);
    i_done   = !rst && state_q == BUSY_I && bus.mem_resp && !bus.i_flush;
    d_done   = !rst && (state_q == LOCAL_D || (state_q == BUSY_D && bus.mem_resp));
  end
  assign bus.mem_addr  = drive ? addr_q : '0;
  assign bus.mem_wdata = drive ? wdata_q : '0;
  assign bus.mem_rmask = drive ? rmask_q : '0;
  assign bus.mem_wmask = drive ? wmask_q : '0;
  assign bus.i_resp    = i_done;
  assign bus.i_rdata   = i_done ? bus.mem_rdata : '0;
  assign bus.d_resp    = d_done;
  assign bus.d_rdata   = d_done && state_q == BUSY_D ? bus.mem_rdata : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rmask_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rmask_q  <= rmask_d;
      wmask_q  <= wmask_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: per-cycle vector table plus directed streak, flush and reset sequences
module tb_mem_port_arbiter;
  typedef struct {
    string       n;
    logic [31:0] ir, ia, im, fl, dr, da, drm, dwm, dwd, mr, mrd;
    logic [31:0] eir, eird, edr, edrd, ema, emr, emw, emwd;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[32];
  int   nv = 0;
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.MAX_D_STREAK(4)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic zero_in();
    bus.i_req = 0; bus.i_addr = 0; bus.i_rmask = 0; bus.i_flush = 0;
    bus.d_req = 0; bus.d_addr = 0; bus.d_rmask = 0; bus.d_wmask = 0; bus.d_wdata = 0;
    bus.mem_resp = 0; bus.mem_rdata = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    zero_in();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask
  task automatic row(input string n,
                     input logic [31:0] ir, ia, im, fl, dr, da, drm, dwm, dwd, mr, mrd,
                     input logic [31:0] eir, eird, edr, edrd, ema, emr, emw, emwd);
    vecs[nv] = '{n, ir, ia, im, fl, dr, da, drm, dwm, dwd, mr, mrd, eir, eird, edr, edrd, ema, emr, emw, emwd};
    nv++;
  endtask
  task automatic chk_quiet(input string n);
    chk({n, " i_resp"}, 32'(bus.i_resp), 0);
    chk({n, " d_resp"}, 32'(bus.d_resp), 0);
    chk({n, " strobes"}, 32'({bus.mem_rmask, bus.mem_wmask}), 0);
  endtask
  initial begin
    string order;
    int    pend, ng;
    zero_in();
    do_reset();
    @(negedge clk);
    #1;
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_wdata", bus.mem_wdata, 0);
    chk("reset i_rdata", bus.i_rdata, 0);
    chk("reset d_rdata", bus.d_rdata, 0);
    chk_quiet("reset");
    //   name            ir ia          im  fl dr da          drm dwm dwd     mr mrd           eir eird        edr edrd        ema         emr emw emwd
    row("fetch req",     1, 32'h1000, 'hF, 0, 0, 0,         0,  0,  0,      0, 0,            0, 0,           0, 0,           0,          0,  0,  0);
    row("fetch strobe",  1, 32'h1000, 'hF, 0, 0, 0,         0,  0,  0,      0, 0,            0, 0,           0, 0,           32'h1000,  'hF, 0,  0);
    row("fetch resp",    1, 32'h1000, 'hF, 0, 0, 0,         0,  0,  0,      1, 32'hDEADBEEF, 1, 32'hDEADBEEF,0, 0,           32'h1000,  0,  0,  0);
    row("fetch idle",    0, 0,        0,   0, 0, 0,         0,  0,  0,      0, 0,            0, 0,           0, 0,           0,          0,  0,  0);
    row("store req",     0, 0,        0,   0, 1, 32'h2004,  0,  3,  'hABCD, 0, 0,            0, 0,           0, 0,           0,          0,  0,  0);
    row("store strobe",  0, 0,        0,   0, 1, 32'h2004,  0,  3,  'hABCD, 0, 0,            0, 0,           0, 0,           32'h2004,  0,  3,  'hABCD);
    row("store resp",    0, 0,        0,   0, 1, 32'h2004,  0,  3,  'hABCD, 1, 0,            0, 0,           1, 0,           32'h2004,  0,  0,  'hABCD);
    row("store idle",    0, 0,        0,   0, 0, 0,         0,  0,  0,      0, 0,            0, 0,           0, 0,           0,          0,  0,  0);
    row("load req",      0, 0,        0,   0, 1, 32'h3000,  'hC, 0, 0,      0, 0,            0, 0,           0, 0,           0,          0,  0,  0);
    row("load strobe",   0, 0,        0,   0, 1, 32'h3000,  'hC, 0, 0,      0, 0,            0, 0,           0, 0,           32'h3000,  'hC, 0, 0);
    row("load wait",     0, 0,        0,   0, 1, 32'h3000,  'hC, 0, 0,      0, 0,            0, 0,           0, 0,           32'h3000,  0,  0,  0);
    row("load resp",     0, 0,        0,   0, 1, 32'h3000,  'hC, 0, 0,      1, 32'hCAFE0000, 0, 0,           1, 32'hCAFE0000,32'h3000,  0,  0,  0);
    row("load idle",     0, 0,        0,   0, 0, 0,         0,  0,  0,      0, 0,            0, 0,           0, 0,           0,          0,  0,  0);
    row("local req",     0, 0,        0,   0, 1, 32'h40,    0,  0,  0,      0, 0,            0, 0,           0, 0,           0,          0,  0,  0);
    row("local resp",    0, 0,        0,   0, 1, 32'h40,    0,  0,  0,      0, 0,            0, 0,           1, 0,           0,          0,  0,  0);
    row("stray resp",    0, 0,        0,   0, 0, 0,         0,  0,  0,      1, 32'h55,       0, 0,           0, 0,           0,          0,  0,  0);
    row("dual req",      1, 32'h600,  'hF, 0, 1, 32'h500,   'hF, 0, 0,      0, 0,            0, 0,           0, 0,           0,          0,  0,  0);
    row("dual d strobe", 1, 32'h600,  'hF, 0, 1, 32'h500,   'hF, 0, 0,      0, 0,            0, 0,           0, 0,           32'h500,   'hF, 0, 0);
    row("dual d resp",   1, 32'h600,  'hF, 0, 1, 32'h500,   'hF, 0, 0,      1, 32'h13579BDF, 0, 0,           1, 32'h13579BDF,32'h500,   0,  0,  0);
    row("dual again",    1, 32'h600,  'hF, 0, 1, 32'h500,   'hF, 0, 0,      0, 0,            0, 0,           0, 0,           0,          0,  0,  0);
    row("latched strobe",0, 0,        0,   0, 0, 32'h999,   0,  0,  0,      0, 0,            0, 0,           0, 0,           32'h500,   'hF, 0, 0);
    row("latched resp",  0, 0,        0,   0, 0, 0,         0,  0,  0,      1, 0,            0, 0,           1, 0,           32'h500,   0,  0,  0);
    row("final idle",    0, 0,        0,   0, 0, 0,         0,  0,  0,      0, 0,            0, 0,           0, 0,           0,          0,  0,  0);
    for (int k = 0; k < nv; k++) begin
      @(negedge clk);
      bus.i_req = vecs[k].ir[0]; bus.i_addr = vecs[k].ia; bus.i_rmask = vecs[k].im[3:0]; bus.i_flush = vecs[k].fl[0];
      bus.d_req = vecs[k].dr[0]; bus.d_addr = vecs[k].da; bus.d_rmask = vecs[k].drm[3:0];
      bus.d_wmask = vecs[k].dwm[3:0]; bus.d_wdata = vecs[k].dwd;
      bus.mem_resp = vecs[k].mr[0]; bus.mem_rdata = vecs[k].mrd;
      #1;
      chk({vecs[k].n, " i_resp"}, 32'(bus.i_resp), vecs[k].eir);
      chk({vecs[k].n, " i_rdata"}, bus.i_rdata, vecs[k].eird);
      chk({vecs[k].n, " d_resp"}, 32'(bus.d_resp), vecs[k].edr);
      chk({vecs[k].n, " d_rdata"}, bus.d_rdata, vecs[k].edrd);
      chk({vecs[k].n, " mem_addr"}, bus.mem_addr, vecs[k].ema);
      chk({vecs[k].n, " mem_rmask"}, 32'(bus.mem_rmask), vecs[k].emr);
      chk({vecs[k].n, " mem_wmask"}, 32'(bus.mem_wmask), vecs[k].emw);
      chk({vecs[k].n, " mem_wdata"}, bus.mem_wdata, vecs[k].emwd);
    end
    // both sides requesting continuously, memory answering one cycle after each strobe
    do_reset();
    @(negedge clk);
    bus.i_req = 1; bus.i_addr = 32'h100; bus.i_rmask = 4'hF;
    bus.d_req = 1; bus.d_addr = 32'h200; bus.d_rmask = 4'hF;
    order = "";
    pend = 0;
    ng = 0;
    for (int c = 0; c < 100 && ng < 10; c++) begin
      @(negedge clk);
      bus.mem_resp = pend[0];
      pend = 0;
      #1;
      if (bus.mem_rmask != 0) begin
        if (bus.mem_addr == 32'h100) begin
          order = {order, "I"};
          chk("streak cleared on I grant", 32'(dut.streak_q), 0);
        end else order = {order, "D"};
        ng++;
        pend = 1;
      end
    end
    tests++;
    if (order != "DDDDIDDDDI") begin
      fails++;
      $display("FAIL grant order: got %s want DDDDIDDDDI", order);
    end
    // flush the cycle after an I grant with a 5-cycle memory
    do_reset();
    @(negedge clk);
    bus.i_req = 1; bus.i_addr = 32'h800; bus.i_rmask = 4'hF;
    @(negedge clk);
    bus.i_req = 0; bus.i_flush = 1;
    bus.d_req = 1; bus.d_addr = 32'h900; bus.d_wmask = 4'hF; bus.d_wdata = 32'h11;
    #1;
    chk("flush strobe", 32'(bus.mem_rmask), 32'hF);
    @(negedge clk);
    bus.i_flush = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk_quiet("drain wait");
    end
    @(negedge clk);
    bus.mem_resp = 1; bus.mem_rdata = 32'hBAD0BAD0;
    #1;
    chk("drain i_resp", 32'(bus.i_resp), 0);
    chk("drain i_rdata", bus.i_rdata, 0);
    chk("drain d_resp", 32'(bus.d_resp), 0);
    @(negedge clk);
    bus.mem_resp = 0;
    #1;
    chk("d held in drain", 32'(bus.mem_wmask), 0);
    @(negedge clk);
    #1;
    chk("d strobe after drain", 32'(bus.mem_wmask), 32'hF);
    chk("d addr after drain", bus.mem_addr, 32'h900);
    @(negedge clk);
    bus.mem_resp = 1; bus.mem_rdata = 0;
    #1;
    chk("d resp after drain", 32'(bus.d_resp), 1);
    @(negedge clk);
    zero_in();
    // flush coinciding with the fetch response
    @(negedge clk);
    bus.i_req = 1; bus.i_addr = 32'h840; bus.i_rmask = 4'hF;
    @(negedge clk);
    #1;
    chk("flush+resp strobe", bus.mem_addr, 32'h840);
    @(negedge clk);
    bus.i_flush = 1; bus.mem_resp = 1; bus.mem_rdata = 32'h99;
    #1;
    chk("flush+resp i_resp", 32'(bus.i_resp), 0);
    chk("flush+resp i_rdata", bus.i_rdata, 0);
    @(negedge clk);
    bus.i_flush = 0; bus.mem_resp = 0; bus.i_addr = 32'h880;
    #1;
    chk("redirect idle", 32'(bus.mem_rmask), 0);
    @(negedge clk);
    #1;
    chk("redirect strobe", 32'(bus.mem_rmask), 32'hF);
    chk("redirect addr", bus.mem_addr, 32'h880);
    @(negedge clk);
    bus.mem_resp = 1; bus.mem_rdata = 32'h1234;
    #1;
    chk("redirect i_resp", 32'(bus.i_resp), 1);
    chk("redirect i_rdata", bus.i_rdata, 32'h1234);
    // reset while BUSY_D, then a stale response
    do_reset();
    @(negedge clk);
    bus.d_req = 1; bus.d_addr = 32'hA00; bus.d_rmask = 4'hF;
    @(negedge clk);
    #1;
    chk("pre-reset strobe", bus.mem_addr, 32'hA00);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    bus.d_req = 0; bus.d_addr = 0; bus.d_rmask = 0;
    bus.mem_resp = 1; bus.mem_rdata = 32'h77;
    #1;
    chk_quiet("stale resp");
    chk("stale d_rdata", bus.d_rdata, 0);
    chk("stale i_rdata", bus.i_rdata, 0);
    chk("stale mem_addr", bus.mem_addr, 0);
    @(negedge clk);
    bus.mem_resp = 0;
    bus.i_req = 1; bus.i_addr = 32'hC00; bus.i_rmask = 4'hF;
    @(negedge clk);
    #1;
    chk("post-reset strobe", 32'(bus.mem_rmask), 32'hF);
    chk("post-reset addr", bus.mem_addr, 32'hC00);
    @(negedge clk);
    bus.mem_resp = 1; bus.mem_rdata = 32'h600DF00D;
    #1;
    chk("post-reset i_resp", 32'(bus.i_resp), 1);
    chk("post-reset i_rdata", bus.i_rdata, 32'h600DF00D);
    @(negedge clk);
    zero_in();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
